// File: rtl/frame_capture_buffer.sv
// Frame sink for the generator stream: stores the first TARGET_PIXELS samples of each frame,
// counts surplus samples, and provides a registered random-access read port.
module frame_capture_buffer #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned TARGET_PIXELS = 784,
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned DROP_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  frame_clear,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  frame_done,
   output logic [ADDR_WIDTH:0]   pix_count,
   output logic [DROP_WIDTH-1:0] drop_count,
   output logic [15:0]           frame_total
);

   localparam logic [ADDR_WIDTH:0] PixTarget = (ADDR_WIDTH + 1)'(TARGET_PIXELS);
   localparam logic [ADDR_WIDTH:0] PixLast   = (ADDR_WIDTH + 1)'(TARGET_PIXELS - 1);

   typedef enum logic {StCapture, StDone} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] mem [TARGET_PIXELS];
   logic                  wr_en;
   logic                  rd_in_range;

   // frame_clear wins over a same-cycle sample, so that sample never reaches the RAM.
   assign wr_en       = valid_in && !frame_clear && (state_q == StCapture);
   assign rd_in_range = ({1'b0, rd_addr} < PixTarget);

   // RAM has no reset; contents are only meaningful after frame_done.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[pix_count[ADDR_WIDTH-1:0]] <= data_in;
      end
   end

   // Non-blocking read of mem gives read-first behaviour on a same-address write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_addr] : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StCapture;
         pix_count   <= '0;
         drop_count  <= '0;
         frame_done  <= 1'b0;
         frame_total <= '0;
      end else if (frame_clear) begin
         state_q    <= StCapture;
         pix_count  <= '0;
         drop_count <= '0;
         frame_done <= 1'b0;
      end else if (valid_in) begin
         case (state_q)
            StCapture: begin
               pix_count <= pix_count + 1'b1;
               if (pix_count == PixLast) begin
                  state_q     <= StDone;
                  frame_done  <= 1'b1;
                  frame_total <= frame_total + 1'b1;
               end
            end
            StDone: begin
               if (drop_count != '1) begin
                  drop_count <= drop_count + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_capture_buffer.sv
// Randomized bench for frame_capture_buffer checked against a count-based reference model.
module tb_frame_capture_buffer;

   localparam int Npix = 784;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in;
   logic [15:0] data_in;
   logic        frame_clear;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        frame_done;
   logic [10:0] pix_count;
   logic [15:0] drop_count;
   logic [15:0] frame_total;

   frame_capture_buffer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_in    (valid_in),
      .data_in     (data_in),
      .frame_clear (frame_clear),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .frame_done  (frame_done),
      .pix_count   (pix_count),
      .drop_count  (drop_count),
      .frame_total (frame_total)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: frame progress is just the number of accepted samples.
   logic [15:0] m_mem   [Npix];
   bit          m_known [Npix];
   int          m_pix, m_drop, m_total;
   bit          m_done, m_rd_valid, m_rd_known;
   logic [15:0] m_rd_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_pix = 0; m_drop = 0; m_total = 0; m_done = 0;
      m_rd_valid = 0; m_rd_data = '0; m_rd_known = 1;
      for (int i = 0; i < Npix; i++) m_known[i] = 0;
   endfunction

   function automatic void model_step(bit v, logic [15:0] d, bit clr, bit re, int ra);
      m_rd_valid = re;
      if (re) begin
         if (ra >= Npix) begin
            m_rd_data = '0; m_rd_known = 1;
         end else begin
            m_rd_data = m_mem[ra]; m_rd_known = m_known[ra];
         end
      end
      if (clr) begin
         m_pix = 0; m_drop = 0; m_done = 0;
      end else if (v) begin
         if (m_pix < Npix) begin
            m_mem[m_pix] = d; m_known[m_pix] = 1; m_pix++;
            if (m_pix == Npix) begin
               m_done = 1; m_total = (m_total + 1) % 65536;
            end
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
   endfunction

   task automatic check_outputs();
      check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      check("pix_count", {21'd0, pix_count}, m_pix);
      check("drop_count", {16'd0, drop_count}, m_drop);
      check("frame_total", {16'd0, frame_total}, m_total);
      check("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
      if (m_rd_known) check("rd_data", {16'd0, rd_data}, {16'd0, m_rd_data});
   endtask

   // One clock: apply inputs, advance the model on the edge, compare 1ns later.
   task automatic tick(input bit v, input logic [15:0] d, input bit clr, input bit re,
                       input int ra);
      valid_in = v; data_in = d; frame_clear = clr; rd_en = re; rd_addr = 10'(ra);
      @(posedge clk);
      model_step(v, d, clr, re, ra);
      #1;
      check_outputs();
      valid_in = 0; frame_clear = 0; rd_en = 0;
   endtask

   function automatic logic [15:0] rand_sample();
      logic [15:0] r = 16'($urandom);
      return (r == 16'h7FFF) ? 16'h0000 : r;
   endfunction

   task automatic readback_all(output int n7fff);
      n7fff = 0;
      for (int a = 0; a < Npix; a++) begin
         tick(0, '0, 0, 1, a);
         if (rd_data == 16'h7FFF) n7fff++;
      end
   endtask

   initial begin
      int cnt, n7;
      bit v;
      logic [15:0] d;
      rst_n = 0; valid_in = 0; data_in = '0; frame_clear = 0; rd_en = 0; rd_addr = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1;

      // Frame 1: ramp -392..391 every cycle.
      for (int i = 0; i < Npix; i++) begin
         if (i == Npix - 1) check("done_before_last", {31'd0, frame_done}, 32'd0);
         tick(1, 16'(i - 392), 0, 0, 0);
      end
      check("f1_done", {31'd0, frame_done}, 32'd1);
      check("f1_pix", {21'd0, pix_count}, 32'd784);
      check("f1_total", {16'd0, frame_total}, 32'd1);
      check("f1_drop", {16'd0, drop_count}, 32'd0);
      tick(0, '0, 0, 1, 0);
      check("rd_addr0", {16'd0, rd_data}, 32'h0000FE78);
      check("rd_addr0_valid", {31'd0, rd_valid}, 32'd1);
      tick(0, '0, 0, 1, 391);
      check("rd_addr391", {16'd0, rd_data}, 32'h0000FFFF);
      tick(0, '0, 0, 1, 783);
      check("rd_addr783", {16'd0, rd_data}, 32'h00000187);
      tick(0, '0, 0, 0, 0);
      check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);

      // Flush: 50 surplus zeros are counted, never stored.
      repeat (50) tick(1, '0, 0, 0, 0);
      check("flush_drop", {16'd0, drop_count}, 32'd50);
      check("flush_pix", {21'd0, pix_count}, 32'd784);
      readback_all(n7);

      // Frame with ~60% valid duty.
      tick(0, '0, 1, 0, 0);
      cnt = 0;
      while (cnt < Npix) begin
         v = ($urandom_range(0, 99) < 60);
         tick(v, rand_sample(), 0, 0, 0);
         if (v) cnt++;
      end
      check("duty_done", {31'd0, frame_done}, 32'd1);
      readback_all(n7);

      // frame_clear swallows a same-cycle 0x7FFF sample.
      tick(1, 16'h7FFF, 1, 0, 0);
      check("clr_pix", {21'd0, pix_count}, 32'd0);
      for (int i = 0; i < Npix; i++) tick(1, rand_sample(), 0, 0, 0);
      check("clr_pix_full", {21'd0, pix_count}, 32'd784);
      readback_all(n7);
      check("no_7fff_stored", n7, 32'd0);

      // Asynchronous reset mid-frame at pix_count=300.
      tick(0, '0, 1, 0, 0);
      for (int i = 0; i < 300; i++) tick(1, rand_sample(), 0, 0, 0);
      check("pre_rst_pix", {21'd0, pix_count}, 32'd300);
      tick(0, '0, 0, 1, 5);
      #3 rst_n = 0;
      #1;
      model_reset();
      check("arst_pix", {21'd0, pix_count}, 32'd0);
      check("arst_total", {16'd0, frame_total}, 32'd0);
      check("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("arst_rd_data", {16'd0, rd_data}, 32'd0);
      check("arst_done", {31'd0, frame_done}, 32'd0);
      check("arst_drop", {16'd0, drop_count}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1;
      for (int i = 0; i < Npix; i++) begin
         d = (i == 10) ? 16'h0AAA : rand_sample();
         tick(1, d, 0, 0, 0);
      end
      check("post_rst_total", {16'd0, frame_total}, 32'd1);
      readback_all(n7);

      // Out-of-range read and read-first collision at address 10.
      tick(0, '0, 1, 0, 0);
      for (int i = 0; i < 10; i++) tick(1, rand_sample(), 0, 0, 0);
      tick(1, 16'h1234, 0, 1, 10);
      check("rd_first_old", {16'd0, rd_data}, 32'h00000AAA);
      tick(0, '0, 0, 1, 10);
      check("rd_reread_new", {16'd0, rd_data}, 32'h00001234);
      tick(0, '0, 0, 1, 900);
      check("rd_oob_data", {16'd0, rd_data}, 32'd0);
      check("rd_oob_valid", {31'd0, rd_valid}, 32'd1);
      for (int i = 11; i < Npix; i++) tick(1, rand_sample(), 0, 0, 0);
      check("last_total", {16'd0, frame_total}, 32'd2);
      readback_all(n7);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
